game_sequencer: RTL and testbench

- Frame-level game controller that sequences a round: attract → start countdown → play → hit freeze → game over or win.
- Owns the player lives counter and the post-hit invulnerability window.
- Gates and restarts the entity logic (player, dragon, sheep) and drives the heart entity and the status colour to the PPU/display path.
- Sits between the collision detector, the sync generator and the entity blocks in the top level.

---
 rtl/game_sequencer_pkg.sv | 31 +++
 rtl/game_sequencer_frame_timer.sv | 26 ++
 rtl/game_sequencer.sv | 142 ++++++++++++++
 tb/tb_game_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared encodings and default frame constants for the round sequencer.
// Pure declarations: no latency, no flow control.
package game_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT  = 3'd0,
    ST_START    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_FREEZE   = 3'd3,
    ST_GAMEOVER = 3'd4,
    ST_WIN      = 3'd5
  } state_t;

  typedef enum logic {
    COL_NORMAL = 1'b0,
    COL_RED    = 1'b1
  } colour_t;

  localparam int DEF_LIVES         = 3;
  localparam int DEF_START_FRAMES  = 60;
  localparam int DEF_FREEZE_FRAMES = 30;
  localparam int DEF_INVULN_FRAMES = 120;
  localparam int DEF_FLASH_SHIFT   = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Per-frame saturating counter with clear and terminal-count flag.
// Count updates 1 clk after clear/tick; no backpressure, holds at term.
module frame_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  assign done = (count == term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (tick && !done)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/game_sequencer.sv
// Round sequencer: attract, countdown, play, hit freeze, game over / win.
// Outputs update 1 clk after the frame_end edge; no backpressure.
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES         = DEF_LIVES,
  parameter int START_FRAMES  = DEF_START_FRAMES,
  parameter int FREEZE_FRAMES = DEF_FREEZE_FRAMES,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int FLASH_SHIFT   = DEF_FLASH_SHIFT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_end,
  input  logic       start_btn,
  input  logic       player_hit,
  input  logic [6:0] dragon_segments,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic       logic_enable,
  output logic       logic_reset,
  output logic       invuln,
  output logic       player_blink,
  output logic       hit_pulse,
  output logic       status_red
);

  localparam int CW = $clog2(max3(START_FRAMES, FREEZE_FRAMES, INVULN_FRAMES));
  localparam logic [CW-1:0] START_TERM  = CW'(START_FRAMES - 1);
  localparam logic [CW-1:0] FREEZE_TERM = CW'(FREEZE_FRAMES - 1);
  localparam logic [CW-1:0] INVULN_TERM = CW'(INVULN_FRAMES - 1);

  state_t        st;
  colour_t       colour;
  logic          start_q, start_lat, hit_lat;
  logic          start_rise, start_go, hit_go;
  logic          counting, phase_done, inv_done;
  logic [CW-1:0] phase_term, phase_cnt, inv_cnt;
  logic          unused_cnt_bits;

  assign start_rise = start_btn & ~start_q;
  // Events arriving on the frame_end cycle itself still count for this frame.
  assign start_go   = start_lat | start_rise;
  assign hit_go     = hit_lat | player_hit;

  assign counting   = (st == ST_START) || (st == ST_FREEZE);
  assign phase_term = (st == ST_START) ? START_TERM : FREEZE_TERM;

  // Idle states clear the phase counter so every START/FREEZE begins at 0.
  frame_timer #(.WIDTH(CW)) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (frame_end & ~counting),
    .tick  (frame_end & counting),
    .term  (phase_term),
    .count (phase_cnt),
    .done  (phase_done)
  );

  frame_timer #(.WIDTH(CW)) u_invuln (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (frame_end && (st == ST_FREEZE)),
    .tick  (frame_end && (st == ST_PLAY) && invuln),
    .term  (INVULN_TERM),
    .count (inv_cnt),
    .done  (inv_done)
  );

  assign unused_cnt_bits = ^{phase_cnt, inv_cnt};

  assign state        = st;
  assign logic_enable = (st == ST_PLAY);
  assign colour       = ((st == ST_FREEZE) || (st == ST_GAMEOVER)) ? COL_RED : COL_NORMAL;
  assign status_red   = (colour == COL_RED);
  assign player_blink = invuln & inv_cnt[FLASH_SHIFT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_ATTRACT;
      lives       <= '0;
      invuln      <= 1'b0;
      logic_reset <= 1'b0;
      hit_pulse   <= 1'b0;
      start_q     <= 1'b0;
      start_lat   <= 1'b0;
      hit_lat     <= 1'b0;
    end else begin
      logic_reset <= 1'b0;
      hit_pulse   <= 1'b0;
      start_q     <= start_btn;
      start_lat   <= frame_end ? 1'b0 : start_go;
      hit_lat     <= frame_end ? 1'b0 : hit_go;

      case (st)
        ST_ATTRACT, ST_GAMEOVER, ST_WIN: begin
          if (frame_end && start_go) begin
            st          <= ST_START;
            lives       <= 2'(LIVES);
            invuln      <= 1'b0;
            logic_reset <= 1'b1;
          end
        end
        ST_START: begin
          if (frame_end && phase_done)
            st <= ST_PLAY;
        end
        ST_PLAY: begin
          if (frame_end) begin
            if (dragon_segments == 7'd0) begin
              st     <= ST_WIN;
              invuln <= 1'b0;
            end else if (hit_go && !invuln) begin
              hit_pulse <= 1'b1;
              if (lives <= 2'd1) begin
                lives  <= 2'd0;
                invuln <= 1'b0;
                st     <= ST_GAMEOVER;
              end else begin
                lives <= lives - 2'd1;
                st    <= ST_FREEZE;
              end
            end else if (invuln && inv_done) begin
              invuln <= 1'b0;
            end
          end
        end
        ST_FREEZE: begin
          if (frame_end && phase_done) begin
            st     <= ST_PLAY;
            invuln <= 1'b1;
          end
        end
        default: begin
          st     <= ST_ATTRACT;
          invuln <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed round walk-through plus randomized frames against a frame-level model.
module tb_game_sequencer;

  localparam int LIVES = 3, START_FRAMES = 60, FREEZE_FRAMES = 30, INVULN_FRAMES = 120;
  localparam int FLASH_PERIOD = 8;

  logic       clk, rst_n, frame_end, start_btn, player_hit;
  logic [6:0] dragon_segments;
  logic [2:0] state;
  logic [1:0] lives;
  logic       logic_enable, logic_reset, invuln, player_blink, hit_pulse, status_red;

  int checks = 0;
  int errors = 0;

  // Model: mode number, lives, frames left in the current phase / invulnerability window.
  int m_mode = 0, m_lives = 0, m_phase_left = 0, m_inv_left = 0;
  bit m_lr = 0, m_hp = 0, m_start_seen = 0, m_hit_seen = 0, m_prev_btn = 0;
  bit rise, go, hitnow;

  game_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_end(frame_end), .start_btn(start_btn),
    .player_hit(player_hit), .dragon_segments(dragon_segments), .state(state),
    .lives(lives), .logic_enable(logic_enable), .logic_reset(logic_reset),
    .invuln(invuln), .player_blink(player_blink), .hit_pulse(hit_pulse),
    .status_red(status_red)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model, advanced once per clock edge (or on async reset).
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_lives = 0; m_phase_left = 0; m_inv_left = 0;
        m_lr = 0; m_hp = 0; m_start_seen = 0; m_hit_seen = 0; m_prev_btn = 0;
      end else begin
        rise   = start_btn && !m_prev_btn;
        go     = m_start_seen || rise;
        hitnow = m_hit_seen || player_hit;
        m_lr = 0;
        m_hp = 0;
        if (frame_end) begin
          case (m_mode)
            0, 4, 5: if (go) begin
              m_mode = 1; m_lives = LIVES; m_lr = 1; m_inv_left = 0;
              m_phase_left = START_FRAMES;
            end
            1: begin
              m_phase_left--;
              if (m_phase_left == 0) m_mode = 2;
            end
            2: begin
              if (dragon_segments == 0) begin
                m_mode = 5; m_inv_left = 0;
              end else if (hitnow && m_inv_left == 0) begin
                m_hp = 1;
                if (m_lives > 1) begin
                  m_lives--; m_mode = 3; m_phase_left = FREEZE_FRAMES;
                end else begin
                  m_lives = 0; m_mode = 4;
                end
              end else if (m_inv_left > 0) begin
                m_inv_left--;
              end
            end
            3: begin
              m_phase_left--;
              if (m_phase_left == 0) begin
                m_mode = 2; m_inv_left = INVULN_FRAMES;
              end
            end
            default: m_mode = 0;
          endcase
          m_start_seen = 0;
          m_hit_seen   = 0;
        end else begin
          m_start_seen = go;
          m_hit_seen   = hitnow;
        end
        m_prev_btn = start_btn;
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("state", state, m_mode);
      chk("lives", lives, m_lives);
      chk("logic_enable", logic_enable, (m_mode == 2) ? 1 : 0);
      chk("logic_reset", logic_reset, m_lr);
      chk("hit_pulse", hit_pulse, m_hp);
      chk("status_red", status_red, (m_mode == 3 || m_mode == 4) ? 1 : 0);
      chk("invuln", invuln, (m_inv_left > 0) ? 1 : 0);
      chk("player_blink", player_blink,
          (m_inv_left > 0 && (((INVULN_FRAMES - m_inv_left) / FLASH_PERIOD) % 2 == 1)) ? 1 : 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1);
  end

  // One frame of len cycles, frame_end on the last, player_hit on cycles [hl, hh).
  task automatic frame(input int len, input int hl, input int hh);
    for (int i = 0; i < len; i++) begin
      frame_end  = (i == len - 1);
      player_hit = (i >= hl && i < hh);
      @(posedge clk); #1;
    end
    frame_end  = 1'b0;
    player_hit = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(3, 0, 0);
  endtask

  int len;

  initial begin
    rst_n = 1'b0; frame_end = 1'b0; start_btn = 1'b0; player_hit = 1'b0;
    dragon_segments = 7'h7f;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", state, 0);
    chk("reset_lives", lives, 0);
    chk("reset_enable", logic_enable, 0);
    rst_n = 1'b1;

    // Attract -> start countdown -> play.
    start_btn = 1'b1;
    frame(4, 0, 0);
    start_btn = 1'b0;
    chk("start_state", state, 1);
    chk("start_lives", lives, 3);
    chk("logic_reset_pulse", logic_reset, 1);
    @(posedge clk); #1;
    chk("logic_reset_single", logic_reset, 0);
    frames(START_FRAMES - 1);
    chk("countdown_not_done", state, 1);
    chk("countdown_enable", logic_enable, 0);
    frames(1);
    chk("play_state", state, 2);
    chk("play_enable", logic_enable, 1);

    // First hit, mid-frame for 5 cycles.
    frame(10, 3, 8);
    chk("hit1_pulse", hit_pulse, 1);
    chk("hit1_lives", lives, 2);
    chk("hit1_state", state, 3);
    chk("hit1_red", status_red, 1);
    @(posedge clk); #1;
    chk("hit1_pulse_single", hit_pulse, 0);
    frames(FREEZE_FRAMES - 1);
    chk("freeze_hold", state, 3);
    frames(1);
    chk("freeze_exit_state", state, 2);
    chk("freeze_exit_invuln", invuln, 1);

    // Hits every frame are ignored for the whole window; blink toggles every 8 frames.
    for (int k = 1; k <= INVULN_FRAMES; k++) begin
      frame(3, 0, 1);
      chk("invuln_no_pulse", hit_pulse, 0);
      if (k == 8)   chk("blink_on_k8", player_blink, 1);
      if (k == 16)  chk("blink_off_k16", player_blink, 0);
      if (k == 119) chk("invuln_k119", invuln, 1);
    end
    chk("invuln_expired", invuln, 0);
    chk("invuln_lives", lives, 2);
    frame(3, 0, 1);
    chk("hit2_lives", lives, 1);
    chk("hit2_state", state, 3);

    // Last life; button pressed during play and held into game over.
    frames(FREEZE_FRAMES);
    frames(INVULN_FRAMES - 1);
    start_btn = 1'b1;
    frames(1);
    chk("play_ignores_start", state, 2);
    frame(3, 1, 2);
    chk("gameover_state", state, 4);
    chk("gameover_lives", lives, 0);
    chk("gameover_enable", logic_enable, 0);
    frames(5);
    chk("held_btn_no_restart", state, 4);
    start_btn = 1'b0;
    frames(1);
    start_btn = 1'b1;
    frames(1);
    start_btn = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_lives", lives, 3);

    // Win and hit in the same frame: win wins, no hit pulse.
    frames(START_FRAMES);
    dragon_segments = 7'd0;
    frame(3, 0, 2);
    dragon_segments = 7'h7f;
    chk("win_state", state, 5);
    chk("win_lives", lives, 3);
    chk("win_no_pulse", hit_pulse, 0);

    // Async reset in the middle of a freeze frame.
    start_btn = 1'b1;
    frames(1);
    start_btn = 1'b0;
    frames(START_FRAMES);
    frame(3, 1, 2);
    chk("pre_reset_state", state, 3);
    frame_end = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_lives", lives, 0);
    chk("async_red", status_red, 0);
    @(posedge clk); #1;
    chk("async_no_logic_reset", logic_reset, 0);
    rst_n = 1'b1;

    // Randomized frames; the model checks every cycle.
    for (int f = 0; f < 1500; f++) begin
      len = $urandom_range(2, 6);
      dragon_segments = ($urandom_range(0, 39) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      for (int i = 0; i < len; i++) begin
        frame_end  = (i == len - 1);
        player_hit = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
        @(posedge clk); #1;
      end
    end
    frame_end = 1'b0;
    player_hit = 1'b0;
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
